// File: rtl/udp_rx.sv
// GMII receive parser: validates preamble/SFD, Ethernet, IPv4 and UDP headers,
// then packs the UDP payload big-endian into 32-bit words for the loopback buffer.
module udp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_00_02
) (
  input  logic        gmii_rxc,
  input  logic        rst_n,
  input  logic        gmii_rxdv,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip,
  output logic [15:0] src_port
);

  // Handshake: rec_en and rec_pkt_done are one-cycle strobes with no back-pressure;
  // rec_data is valid only while rec_en=1, rec_byte_num/src_* are valid from
  // rec_pkt_done until the next accepted frame.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    ETH_HEAD = 3'd2,
    IP_HEAD  = 3'd3,
    UDP_HEAD = 3'd4,
    RX_DATA  = 3'd5,
    RX_END   = 3'd6
  } state_t;

  state_t state, next_state;

  logic [15:0] cnt;
  logic [47:0] eth_dst;
  logic [7:0]  type_hi;
  logic [5:0]  ip_hlen;
  logic [23:0] ip_dst;
  logic [7:0]  len_hi;
  logic [15:0] data_len;
  logic [23:0] acc;
  logic [47:0] mac_sh;
  logic [31:0] ip_sh;
  logic [15:0] port_sh;

  logic        dst_mac_ok;
  logic        eth_ok;
  logic [15:0] udp_len;
  logic        ip_hdr_last;
  logic        last_byte;
  logic        word_end;

  assign dst_mac_ok  = (eth_dst == BOARD_MAC) || (eth_dst == {48{1'b1}});
  assign eth_ok      = dst_mac_ok && ({type_hi, gmii_rxd} == 16'h0800);
  assign udp_len     = {len_hi, gmii_rxd};
  assign ip_hdr_last = (cnt == ({10'd0, ip_hlen} - 16'd1));
  assign last_byte   = (cnt == (data_len - 16'd1));
  assign word_end    = (cnt[1:0] == 2'd3) || last_byte;

  always_ff @(posedge gmii_rxc) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        // A non-preamble byte on an idle line means we joined mid-frame.
        if (gmii_rxdv) next_state = (gmii_rxd == 8'h55) ? PREAMBLE : RX_END;
      end
      PREAMBLE: begin
        if (!gmii_rxdv) next_state = IDLE;
        else if (cnt == 16'd7) next_state = (gmii_rxd == 8'hD5) ? ETH_HEAD : RX_END;
        else if (gmii_rxd != 8'h55) next_state = RX_END;
      end
      ETH_HEAD: begin
        if (!gmii_rxdv) next_state = IDLE;
        else if (cnt == 16'd13) next_state = eth_ok ? IP_HEAD : RX_END;
      end
      IP_HEAD: begin
        if (!gmii_rxdv) next_state = IDLE;
        else if (cnt == 16'd0 && (gmii_rxd[7:4] != 4'd4 || gmii_rxd[3:0] < 4'd5))
          next_state = RX_END;
        else if (cnt == 16'd9 && gmii_rxd != 8'd17) next_state = RX_END;
        else if (cnt == 16'd19 && {ip_dst, gmii_rxd} != BOARD_IP) next_state = RX_END;
        else if (ip_hdr_last) next_state = UDP_HEAD;
      end
      UDP_HEAD: begin
        if (!gmii_rxdv) next_state = IDLE;
        else if (cnt == 16'd5 && udp_len < 16'd8) next_state = RX_END;
        else if (cnt == 16'd7) next_state = (data_len == 16'd0) ? RX_END : RX_DATA;
      end
      RX_DATA: begin
        if (!gmii_rxdv) next_state = IDLE;
        else if (last_byte) next_state = RX_END;
      end
      RX_END: begin
        if (!gmii_rxdv) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge gmii_rxc) begin
    if (!rst_n) begin
      cnt          <= 16'd0;
      eth_dst      <= 48'd0;
      type_hi      <= 8'd0;
      ip_hlen      <= 6'd0;
      ip_dst       <= 24'd0;
      len_hi       <= 8'd0;
      data_len     <= 16'd0;
      acc          <= 24'd0;
      mac_sh       <= 48'd0;
      ip_sh        <= 32'd0;
      port_sh      <= 16'd0;
      rec_en       <= 1'b0;
      rec_data     <= 32'd0;
      rec_pkt_done <= 1'b0;
      rec_byte_num <= 16'd0;
      src_mac      <= 48'd0;
      src_ip       <= 32'd0;
      src_port     <= 16'd0;
    end else begin
      rec_en       <= 1'b0;
      rec_pkt_done <= 1'b0;

      // The first preamble byte is consumed in IDLE, so PREAMBLE starts at 1.
      if (next_state != state)
        cnt <= (state == IDLE && next_state == PREAMBLE) ? 16'd1 : 16'd0;
      else if (gmii_rxdv)
        cnt <= cnt + 16'd1;

      if (gmii_rxdv) begin
        case (state)
          ETH_HEAD: begin
            if (cnt < 16'd6)       eth_dst <= {eth_dst[39:0], gmii_rxd};
            else if (cnt < 16'd12) mac_sh  <= {mac_sh[39:0], gmii_rxd};
            else if (cnt == 16'd12) type_hi <= gmii_rxd;
          end
          IP_HEAD: begin
            if (cnt == 16'd0) ip_hlen <= {gmii_rxd[3:0], 2'b00};
            if (cnt >= 16'd12 && cnt <= 16'd15) ip_sh <= {ip_sh[23:0], gmii_rxd};
            if (cnt >= 16'd16 && cnt <= 16'd18) ip_dst <= {ip_dst[15:0], gmii_rxd};
          end
          UDP_HEAD: begin
            if (cnt < 16'd2)  port_sh <= {port_sh[7:0], gmii_rxd};
            if (cnt == 16'd4) len_hi <= gmii_rxd;
            if (cnt == 16'd5) data_len <= udp_len - 16'd8;
            if (cnt == 16'd7 && data_len == 16'd0) begin
              rec_pkt_done <= 1'b1;
              rec_byte_num <= data_len;
              src_mac      <= mac_sh;
              src_ip       <= ip_sh;
              src_port     <= port_sh;
            end
          end
          RX_DATA: begin
            acc <= {acc[15:0], gmii_rxd};
            if (word_end) begin
              rec_en <= 1'b1;
              // A short final word is left-justified with zero fill.
              case (cnt[1:0])
                2'd0: rec_data <= {gmii_rxd, 24'd0};
                2'd1: rec_data <= {acc[7:0], gmii_rxd, 16'd0};
                2'd2: rec_data <= {acc[15:0], gmii_rxd, 8'd0};
                2'd3: rec_data <= {acc, gmii_rxd};
                default: rec_data <= 32'd0;
              endcase
            end
            if (last_byte) begin
              rec_pkt_done <= 1'b1;
              rec_byte_num <= data_len;
              src_mac      <= mac_sh;
              src_ip       <= ip_sh;
              src_port     <= port_sh;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udp_rx.sv
// Randomized scoreboard bench for udp_rx: frames are built from field descriptors,
// expected payload words and completion records are queued, a monitor pops and compares.
module tb_udp_rx;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = 32'hC0_A8_00_02;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxdv = 1'b0;
  logic [7:0]  rxd = 8'd0;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_port;

  always #5 clk = ~clk;

  udp_rx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP)) dut (
    .gmii_rxc    (clk),
    .rst_n       (rst_n),
    .gmii_rxdv   (rxdv),
    .gmii_rxd    (rxd),
    .rec_en      (rec_en),
    .rec_data    (rec_data),
    .rec_pkt_done(rec_pkt_done),
    .rec_byte_num(rec_byte_num),
    .src_mac     (src_mac),
    .src_ip      (src_ip),
    .src_port    (src_port)
  );

  typedef struct packed {
    logic [15:0] num;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
  } done_t;

  typedef struct {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] etype;
    logic [7:0]  sfd;
    logic [7:0]  vihl;
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] sport;
    logic [15:0] ulen;
    int          trunc;
    int          rst_at;
  } frame_t;

  logic [31:0] exp_q[$];
  done_t       done_q[$];
  logic [7:0]  pay[$];
  logic [47:0] last_mac = 48'd0;
  logic [31:0] last_ip = 32'd0;
  logic [15:0] last_port = 16'd0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mon_w;
  done_t       mon_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero();
    check("zero_rec_en", {63'd0, rec_en}, 64'd0);
    check("zero_rec_data", {32'd0, rec_data}, 64'd0);
    check("zero_rec_pkt_done", {63'd0, rec_pkt_done}, 64'd0);
    check("zero_rec_byte_num", {48'd0, rec_byte_num}, 64'd0);
    check("zero_src_mac", {16'd0, src_mac}, 64'd0);
    check("zero_src_ip", {32'd0, src_ip}, 64'd0);
    check("zero_src_port", {48'd0, src_port}, 64'd0);
  endtask

  // Monitor: every strobe must match the head of the corresponding queue.
  always @(posedge clk) begin
    #1;
    if (rec_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rec_en_unexpected: got data %h with no word expected", rec_data);
      end else begin
        mon_w = exp_q.pop_front();
        check("rec_data", {32'd0, rec_data}, {32'd0, mon_w});
      end
    end
    if (rec_pkt_done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected: got byte_num %0d with no frame expected", rec_byte_num);
      end else begin
        mon_d = done_q.pop_front();
        check("rec_byte_num", {48'd0, rec_byte_num}, {48'd0, mon_d.num});
        check("src_mac", {16'd0, src_mac}, {16'd0, mon_d.mac});
        check("src_ip", {32'd0, src_ip}, {32'd0, mon_d.ip});
        check("src_port", {48'd0, src_port}, {48'd0, mon_d.port});
        check("done_with_last_en", {63'd0, rec_en}, {63'd0, (mon_d.num != 16'd0)});
      end
    end
  end

  function automatic frame_t good_frame();
    frame_t f;
    f.dst_mac = BOARD_MAC;
    f.src_mac = {16'($urandom), 32'($urandom)};
    f.etype   = 16'h0800;
    f.sfd     = 8'hD5;
    f.vihl    = 8'h45;
    f.proto   = 8'd17;
    f.src_ip  = 32'($urandom);
    f.dst_ip  = BOARD_IP;
    f.sport   = 16'($urandom);
    f.ulen    = 16'd8;
    f.trunc   = -1;
    f.rst_at  = -1;
    return f;
  endfunction

  task automatic make_pay(input int n);
    pay = {};
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_frame(input frame_t f);
    logic [7:0]  b[$];
    logic [15:0] tl;
    logic [31:0] w;
    done_t       d;
    int          hlen, n, nw, pstart, idx;
    bit          ok, full;
    b = {};
    repeat (7) b.push_back(8'h55);
    b.push_back(f.sfd);
    for (int i = 5; i >= 0; i--) b.push_back(f.dst_mac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(f.src_mac[i*8 +: 8]);
    b.push_back(f.etype[15:8]);
    b.push_back(f.etype[7:0]);
    hlen = (f.vihl[3:0] < 4'd5) ? 20 : int'(f.vihl[3:0]) * 4;
    tl = 16'(hlen) + f.ulen;
    b.push_back(f.vihl);
    b.push_back(8'h00);
    b.push_back(tl[15:8]);
    b.push_back(tl[7:0]);
    b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h40); b.push_back(8'h00);
    b.push_back(8'd64);
    b.push_back(f.proto);
    b.push_back(8'h00); b.push_back(8'h00);
    for (int i = 3; i >= 0; i--) b.push_back(f.src_ip[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(f.dst_ip[i*8 +: 8]);
    repeat (hlen - 20) b.push_back(8'h00);
    b.push_back(f.sport[15:8]);
    b.push_back(f.sport[7:0]);
    b.push_back(8'h13); b.push_back(8'h88);
    b.push_back(f.ulen[15:8]);
    b.push_back(f.ulen[7:0]);
    b.push_back(8'h00); b.push_back(8'h00);
    pstart = b.size();
    foreach (pay[i]) b.push_back(pay[i]);
    if (f.trunc >= 0) begin
      while (b.size() > pstart + f.trunc) void'(b.pop_back());
    end else begin
      repeat (4) b.push_back(8'($urandom_range(0, 255)));
    end

    // Reference model: acceptance decided straight from the header fields.
    n = (f.ulen >= 16'd8) ? int'(f.ulen) - 8 : 0;
    ok = (f.sfd == 8'hD5) && (f.dst_mac == BOARD_MAC || f.dst_mac == 48'hFFFF_FFFF_FFFF) &&
         (f.etype == 16'h0800) && (f.vihl[7:4] == 4'd4) && (f.vihl[3:0] >= 4'd5) &&
         (f.proto == 8'd17) && (f.dst_ip == BOARD_IP) && (f.ulen >= 16'd8);
    full = (f.trunc < 0) && (f.rst_at < 0);
    if (ok) begin
      if (full)            nw = (n + 3) / 4;
      else if (f.trunc >= 0) nw = f.trunc / 4;
      else                 nw = f.rst_at / 4;
      for (int wi = 0; wi < nw; wi++) begin
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
          idx = wi * 4 + j;
          w = {w[23:0], (idx < n) ? pay[idx] : 8'h00};
        end
        exp_q.push_back(w);
      end
      if (full) begin
        d.num  = 16'(n);
        d.mac  = f.src_mac;
        d.ip   = f.src_ip;
        d.port = f.sport;
        done_q.push_back(d);
        last_mac  = f.src_mac;
        last_ip   = f.src_ip;
        last_port = f.sport;
      end
    end
    if (f.rst_at >= 0) begin
      last_mac  = 48'd0;
      last_ip   = 32'd0;
      last_port = 16'd0;
    end

    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      rxdv  = 1'b1;
      rxd   = b[i];
      rst_n = !(f.rst_at >= 0 && i == pstart + f.rst_at);
      if (!rst_n) begin
        @(posedge clk);
        #1;
        check_outputs_zero();
      end
    end
    @(negedge clk);
    rxdv  = 1'b0;
    rxd   = 8'd0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  frame_t fr;
  int     kind;

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fr = good_frame(); fr.ulen = 16'd16;
    pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(fr);

    fr = good_frame(); fr.dst_mac = 48'hFFFF_FFFF_FFFF; fr.ulen = 16'd13;
    pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_frame(fr);

    fr = good_frame(); fr.dst_ip = 32'hC0A8_0003; fr.ulen = 16'd12;
    make_pay(4);
    send_frame(fr);
    fr = good_frame(); fr.etype = 16'h0806; fr.ulen = 16'd12;
    send_frame(fr);
    fr = good_frame(); fr.sfd = 8'h55; fr.ulen = 16'd12;
    send_frame(fr);
    fr = good_frame(); fr.ulen = 16'd12;
    send_frame(fr);

    fr = good_frame(); fr.vihl = 8'h46; fr.ulen = 16'd8;
    pay = {};
    send_frame(fr);

    fr = good_frame(); fr.ulen = 16'd16; fr.trunc = 3;
    make_pay(8);
    send_frame(fr);
    check("trunc_src_mac", {16'd0, src_mac}, {16'd0, last_mac});
    check("trunc_src_ip", {32'd0, src_ip}, {32'd0, last_ip});
    check("trunc_src_port", {48'd0, src_port}, {48'd0, last_port});

    fr = good_frame(); fr.ulen = 16'd17;
    make_pay(9);
    send_frame(fr);

    fr = good_frame(); fr.ulen = 16'd16; fr.rst_at = 6;
    pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(fr);

    fr = good_frame(); fr.ulen = 16'd14;
    make_pay(6);
    send_frame(fr);

    for (int it = 0; it < 30; it++) begin
      fr = good_frame();
      fr.ulen = 16'($urandom_range(8, 40));
      kind = $urandom_range(0, 11);
      case (kind)
        0: begin
          fr.dst_mac = {16'($urandom), 32'($urandom)};
          if (fr.dst_mac == BOARD_MAC || fr.dst_mac == 48'hFFFF_FFFF_FFFF) fr.dst_mac[0] = ~fr.dst_mac[0];
        end
        1: fr.etype = 16'h0806;
        2: fr.dst_ip = BOARD_IP ^ (32'd1 << $urandom_range(0, 31));
        3: fr.proto = 8'd6;
        4: fr.vihl = {4'h4, 4'($urandom_range(0, 4))};
        5: fr.vihl = {4'h4, 4'($urandom_range(6, 15))};
        6: fr.dst_mac = 48'hFFFF_FFFF_FFFF;
        7: fr.ulen = 16'($urandom_range(0, 7));
        8: fr.vihl = 8'h65;
        default: ;
      endcase
      make_pay((fr.ulen >= 16'd8) ? int'(fr.ulen) - 8 : 0);
      send_frame(fr);
    end

    repeat (10) @(negedge clk);
    check("words_outstanding", 64'(exp_q.size()), 64'd0);
    check("frames_outstanding", 64'(done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
